d4_bcd_scan_display: RTL and testbench

Multiplexed 4-digit 7-segment display driver that consumes the four BCD digit buses produced by the 4-digit BCD counter (ABCD1 = most significant, ABCD4 = least significant). It snapshots the digits once per scan frame, decodes one digit at a time to segment patterns, and time-multiplexes them onto a shared segment bus with one-hot digit enables. Optional leading-zero blanking and a dash pattern for invalid BCD codes are included. The block sits between the counter and the board's display pins.

---
 rtl/bcd_display_pkg.sv | 37 +++
 rtl/d4_bcd_scan_display_if.sv | 24 ++
 rtl/bcd_to_7seg.sv | 26 ++
 rtl/d4_bcd_scan_display.sv | 94 +++++++++
 tb/tb_d4_bcd_scan_display.sv | 125 ++++++++++++
 5 files changed

// File: rtl/bcd_display_pkg.sv
// rtl/bcd_display_pkg.sv - shared segment/anode constants and types for BCD display blocks
package bcd_display_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;
    typedef logic [3:0] an_t;

    // segment order {a,b,c,d,e,f,g}, active-high
    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;
    localparam seg_t SEG_DASH  = 7'b0000001;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam an_t AN_NONE = 4'b0000;
    localparam an_t AN_D1   = 4'b1000;
    localparam an_t AN_D2   = 4'b0100;
    localparam an_t AN_D3   = 4'b0010;
    localparam an_t AN_D4   = 4'b0001;

    function automatic an_t an_onehot(input logic [1:0] idx);
        case (idx)
            2'd0:    return AN_D1;
            2'd1:    return AN_D2;
            2'd2:    return AN_D3;
            default: return AN_D4;
        endcase
    endfunction

endpackage

// File: rtl/d4_bcd_scan_display_if.sv
// rtl/d4_bcd_scan_display_if.sv - digit inputs and multiplexed display outputs
interface d4_bcd_scan_display_if;
    import bcd_display_pkg::*;

    bcd_t abcd1;
    bcd_t abcd2;
    bcd_t abcd3;
    bcd_t abcd4;
    logic en;
    seg_t seg;
    an_t  an;
    logic frame;

    modport master (
        output abcd1, abcd2, abcd3, abcd4, en,
        input  seg, an, frame
    );

    modport slave (
        input  abcd1, abcd2, abcd3, abcd4, en,
        output seg, an, frame
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// rtl/bcd_to_7seg.sv - combinational BCD to 7-segment decode, dash for codes 10-15
module bcd_to_7seg
    import bcd_display_pkg::*;
(
    input  bcd_t bcd,
    output seg_t seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/d4_bcd_scan_display.sv
// rtl/d4_bcd_scan_display.sv - 4-digit multiplexed 7-segment driver with per-frame snapshot
module d4_bcd_scan_display
    import bcd_display_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter bit BLANK_LZ = 1'b1
) (
    input logic clk,
    input logic rst,
    d4_bcd_scan_display_if.slave bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    bcd_t [3:0]       snap;
    bcd_t [3:0]       cur;
    bcd_t             digit;
    seg_t             dec;
    seg_t             seg_next;
    seg_t             seg_q;
    an_t              an_q;
    logic             frame_q;
    logic             tick;
    logic             frame_start;
    logic             z1, z2, z3;
    logic             blank;

    assign tick        = (cnt == CNT_LAST);
    assign frame_start = tick && (idx == 2'd0);

    // At a capturing frame start the first digit comes straight from the inputs,
    // so the whole frame shows one consistent set of values.
    always_comb begin
        if (frame_start && bus.en) begin
            cur = {bus.abcd4, bus.abcd3, bus.abcd2, bus.abcd1};
        end else begin
            cur = snap;
        end
    end

    assign digit = cur[idx];

    // Blank only while this digit and every more-significant one is zero.
    always_comb begin
        z1    = (cur[0] == 4'd0);
        z2    = z1 && (cur[1] == 4'd0);
        z3    = z2 && (cur[2] == 4'd0);
        blank = 1'b0;
        case (idx)
            2'd0:    blank = z1;
            2'd1:    blank = z2;
            2'd2:    blank = z3;
            default: blank = 1'b0;
        endcase
        blank = blank && BLANK_LZ;
    end

    bcd_to_7seg u_dec (
        .bcd (digit),
        .seg (dec)
    );

    assign seg_next = blank ? SEG_BLANK : dec;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            idx     <= 2'd0;
            snap    <= '0;
            seg_q   <= SEG_BLANK;
            an_q    <= AN_NONE;
            frame_q <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            frame_q <= frame_start;
            if (tick) begin
                idx   <= idx + 2'd1;
                seg_q <= seg_next;
                an_q  <= an_onehot(idx);
            end
            if (frame_start && bus.en) begin
                snap <= cur;
            end
        end
    end

    assign bus.seg   = seg_q;
    assign bus.an    = an_q;
    assign bus.frame = frame_q;

endmodule

// File: tb/tb_d4_bcd_scan_display.sv
// tb/tb_d4_bcd_scan_display.sv - directed self-checking bench for d4_bcd_scan_display
module tb_d4_bcd_scan_display;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [6:0] pat [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                             7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    logic [6:0] dash;
    logic [6:0] blk;
    logic [3:0] an_exp [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    d4_bcd_scan_display_if if_a ();
    d4_bcd_scan_display_if if_b ();
    d4_bcd_scan_display_if if_c ();

    d4_bcd_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    d4_bcd_scan_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    d4_bcd_scan_display #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                          input logic [3:0] d4, input logic e);
        if_a.abcd1 = d1; if_a.abcd2 = d2; if_a.abcd3 = d3; if_a.abcd4 = d4; if_a.en = e;
        if_b.abcd1 = d1; if_b.abcd2 = d2; if_b.abcd3 = d3; if_b.abcd4 = d4; if_b.en = e;
        if_c.abcd1 = d1; if_c.abcd2 = d2; if_c.abcd3 = d3; if_c.abcd4 = d4; if_c.en = e;
    endtask

    // Entered one edge before a frame start; leaves one edge before the next.
    task automatic frame_chk(input string tag,
                             input logic [6:0] a1, input logic [6:0] a2,
                             input logic [6:0] a3, input logic [6:0] a4,
                             input logic [6:0] b1, input logic [6:0] b2,
                             input logic [6:0] b3, input logic [6:0] b4);
        logic [6:0] ea [4];
        logic [6:0] eb [4];
        ea = '{a1, a2, a3, a4};
        eb = '{b1, b2, b3, b4};
        for (int k = 0; k < 4; k++) begin
            step((k == 0) ? 1 : 4);
            chk($sformatf("%s a.seg d%0d", tag, k + 1), 16'(if_a.seg), 16'(ea[k]));
            chk($sformatf("%s b.seg d%0d", tag, k + 1), 16'(if_b.seg), 16'(eb[k]));
            chk($sformatf("%s a.an d%0d", tag, k + 1), 16'(if_a.an), 16'(an_exp[k]));
            chk($sformatf("%s a.frame d%0d", tag, k + 1), 16'(if_a.frame), 16'(k == 0));
        end
        step(3);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        dash  = 7'b0000001;
        blk   = 7'b0000000;
        rst   = 1'b1;
        set_in(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        step(3);
        chk("reset a.seg", 16'(if_a.seg), 16'h0);
        chk("reset a.an", 16'(if_a.an), 16'h0);
        chk("reset a.frame", 16'(if_a.frame), 16'h0);
        chk("reset c.an", 16'(if_c.an), 16'h0);

        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk($sformatf("startup a.an c%0d", i), 16'(if_a.an), 16'h0);
            chk($sformatf("startup a.frame c%0d", i), 16'(if_a.frame), 16'h0);
            chk($sformatf("div1 c.an c%0d", i), 16'(if_c.an), 16'(an_exp[i-1]));
            chk($sformatf("div1 c.seg c%0d", i), 16'(if_c.seg), 16'(pat[i]));
            chk($sformatf("div1 c.frame c%0d", i), 16'(if_c.frame), 16'(i == 1));
        end
        frame_chk("count1234", pat[1], pat[2], pat[3], pat[4], pat[1], pat[2], pat[3], pat[4]);

        set_in(4'd0, 4'd0, 4'd7, 4'd0, 1'b1);
        frame_chk("lz0070", blk, blk, pat[7], pat[0], pat[0], pat[0], pat[7], pat[0]);

        set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        frame_chk("zeros", blk, blk, blk, pat[0], pat[0], pat[0], pat[0], pat[0]);

        set_in(4'hA, 4'd0, 4'd0, 4'hF, 1'b1);
        frame_chk("invalid", dash, pat[0], pat[0], dash, dash, pat[0], pat[0], dash);

        set_in(4'd5, 4'd5, 4'd5, 4'd5, 1'b1);
        frame_chk("en5", pat[5], pat[5], pat[5], pat[5], pat[5], pat[5], pat[5], pat[5]);
        set_in(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
        frame_chk("hold5", pat[5], pat[5], pat[5], pat[5], pat[5], pat[5], pat[5], pat[5]);
        set_in(4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
        frame_chk("en9", pat[9], pat[9], pat[9], pat[9], pat[9], pat[9], pat[9], pat[9]);

        step(1);
        step(8);
        chk("midframe a.an", 16'(if_a.an), 16'h2);
        rst = 1'b1;
        step(1);
        chk("midrst a.an", 16'(if_a.an), 16'h0);
        chk("midrst a.seg", 16'(if_a.seg), 16'h0);
        chk("midrst a.frame", 16'(if_a.frame), 16'h0);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step(1);
            chk($sformatf("restart a.an c%0d", i), 16'(if_a.an), 16'h0);
        end
        frame_chk("after_rst", pat[9], pat[9], pat[9], pat[9], pat[9], pat[9], pat[9], pat[9]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
